dlx_fetch: RTL and testbench
============================

# dlx_fetch

Instruction-fetch stage of the DLX pipeline, directly upstream of the decoder. It owns the program counter, issues word reads to instruction memory over a valid/ready handshake and buffers returned words in a small prefetch queue. It presents instructions to the decoder with the `ID` valid strobe and `i_data_read`-compatible 32-bit words. Redirects from later stages (jumps/branches) flush the queue and restart fetch at the new target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, 2: prefetch queue entries; power of two, 2..8.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_address`  out  32  instruction memory word address (byte address, bits [1:0] always 0).
- `i_read_en`  out  1  read request valid.
- `i_ready`  in  1  memory accepts request and returns data this cycle; ignored when `i_read_en`=0.
- `i_data_read`  in  32  instruction word, valid when `i_read_en & i_ready`.
- `stall`  in  1  decoder cannot accept; holds the head instruction.
- `halt`  in  1  stop issuing new fetches (HALT state).
- `redirect`  in  1  one-cycle pulse: flush and restart at `redirect_target`.
- `redirect_target`  in  32  new PC; bits [1:0] ignored (forced to 0).
- `ID`  out  1  instruction valid to decoder.
- `instr`  out  32  head instruction word.
- `pc_out`  out  32  address of `instr`.

## Operation
- Transfer: occurs on a rising edge where `i_read_en & i_ready`=1. Requester may withdraw `i_read_en` before `i_ready`; no outstanding-request state is kept.
- `i_address` = fetch PC register. On each transfer, the word and its address are pushed to the queue and the PC advances by 4, mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- `i_read_en` = (state==RUN) & (count < DEPTH) & !redirect. Decided purely from registered count; no combinational path from `stall`.
- Queue: FIFO of {word, pc}. `ID` = count != 0; `instr`/`pc_out` = head entry. Pop when `ID & !stall`. Push and pop may occur on the same edge; count is unchanged.
- States:
  - BOOT: entered on reset; `i_read_en`=0. Moves to RUN on the first edge after reset deasserts.
  - RUN: fetching. Moves to HALT when `halt`=1 and `redirect`=0. The queue keeps draining.
  - HALT: `i_read_en`=0 and the queue drains. Moves to RUN only on `redirect` (level of `halt` ignored while in HALT).
- Redirect (any state except BOOT) has highest priority. On that edge:
  - the queue is emptied (count=0) and any same-cycle transfer or pop is discarded;
  - PC = {`redirect_target`[31:2], 2'b00};
  - state = RUN, even if `halt`=1 that cycle.
- `redirect` in BOOT is ignored.
- `halt` and `redirect` in the same cycle: redirect wins and the state is RUN.

## Timing
- Reset values: `i_address`=RESET_PC, `i_read_en`=0, `ID`=0, `instr`=0, `pc_out`=0, count=0, state=BOOT.
- Reset asserted mid-operation clears everything immediately (asynchronously); in-flight data is lost.
- First request: `i_read_en`=1 in the second cycle after reset release, with `i_address`=RESET_PC.
- Latency: transfer on edge t gives `ID`=1 with that word after edge t (registered, no bypass).
- Throughput: with `i_ready` tied to 1 and `stall`=0, one instruction per cycle sustained, and PC increments by 4 every cycle.
- `stall` held: the queue fills to DEPTH, then `i_read_en` drops in the cycle after the filling edge. `instr`/`pc_out` are stable while `ID & stall`.
- Redirect at edge t: `ID`=0 after t. The new request is visible after t with `i_address`=target. The earliest new `ID` is after edge t+1.

## Test plan
- Reset then `i_ready`=1, memory returns the address as data -> `i_address` sequence 0,4,8,...; `ID` high from cycle 3; `instr`==`pc_out` each cycle; no gaps.
- `stall`=1 for 5 cycles during streaming, DEPTH=2 -> at most 2 entries accepted; `i_read_en`=0 once full; `instr` unchanged; release stall -> entries pop in order with no loss or duplication.
- `i_ready` random 30% with `stall` random -> the decoder sees every address in strictly +4 order, with no duplicates.
- `redirect` with target 0x0000_1003 while the queue is full and a transfer occurs the same cycle -> the transfer is dropped; `ID`=0 next cycle; next `i_address`=0x0000_1000; the first new `pc_out`=0x1000.
- `halt` pulse -> `i_read_en` drops, the queue drains, and the block stays idle 10 cycles even with `halt`=0. Then `redirect` to 0x40 together with `halt`=1 -> state RUN and fetch resumes at 0x40.
- Redirect to 0xFFFF_FFF8 -> fetches at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Asserting `reset` mid-stream -> `ID`/`i_read_en` drop immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/dlx_fetch.sv
// dlx_fetch: DLX instruction-fetch stage.
// Owns the fetch PC, issues word reads over a valid/ready handshake and buffers
// returned {word, pc} pairs in a small FIFO that feeds the decoder.
//
// state | meaning
// BOOT  | just out of reset, no requests issued
// RUN   | fetching while the queue has room
// HALT  | no new requests, queue drains; left only via redirect
module dlx_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_address,
  output logic        i_read_en,
  input  logic        i_ready,
  input  logic [31:0] i_data_read,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        ID,
  output logic [31:0] instr,
  output logic [31:0] pc_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   word_d [DEPTH];
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];

  logic push, pop, redirect_eff;

  assign i_read_en    = (state_q == ST_RUN) && (count_q < FULL) && !redirect;
  assign i_address    = pc_q;
  assign ID           = (count_q != '0);
  assign instr        = word_q[rd_q];
  assign pc_out       = addr_q[rd_q];
  assign push         = i_read_en && i_ready;
  assign pop          = ID && !stall;
  // A redirect that arrives before the first RUN cycle has nothing to flush
  // and must not move the PC away from RESET_PC.
  assign redirect_eff = redirect && (state_q != ST_BOOT);

  // Next-state: FSM, PC, queue pointers/count and queue storage.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    word_d  = word_q;
    addr_d  = addr_q;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase

    if (redirect_eff) begin
      state_d = ST_RUN;
      pc_d    = redirect_target & ~32'h3;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      if (push) begin
        word_d[wr_q] = i_data_read;
        addr_d[wr_q] = pc_q;
        wr_d         = wr_q + AW'(1);
        pc_d         = pc_q + 32'd4;
      end
      if (pop) rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset; storage cleared so instr/pc_out reset to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_dlx_fetch.sv
// Directed + randomised checks of dlx_fetch (DEPTH=2, RESET_PC=0).
// The memory returns the bitwise inverse of the address as the instruction word.
module tb_dlx_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read_en;
  logic        i_ready;
  logic [31:0] i_data_read;
  logic        stall;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ID;
  logic [31:0] instr;
  logic [31:0] pc_out;

  int n_tests = 0;
  int n_fail  = 0;

  dlx_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read_en(i_read_en), .i_ready(i_ready),
    .i_data_read(i_data_read),
    .stall(stall), .halt(halt), .redirect(redirect), .redirect_target(redirect_target),
    .ID(ID), .instr(instr), .pc_out(pc_out)
  );

  always #5 clk = ~clk;
  assign i_data_read = ~i_address;

  typedef struct {
    logic        rdy, stl, hlt, rdr;
    logic [31:0] tgt;
    logic        e_id, e_rd;
    logic [31:0] e_addr, e_pc;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(logic rdy, logic stl, logic hlt, logic rdr, logic [31:0] tgt,
                              logic e_id, logic e_rd, logic [31:0] e_addr, logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.hlt = hlt; v.rdr = rdr; v.tgt = tgt;
    v.e_id = e_id; v.e_rd = e_rd; v.e_addr = e_addr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Move to the input-drive point just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic stl, input logic hlt,
                        input logic rdr, input logic [31:0] tgt);
    i_ready = rdy; stall = stl; halt = hlt; redirect = rdr; redirect_target = tgt;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          pops;

    // pc_out column only checked when e_id=1; instr must always equal ~pc_out then.
    vecs[0]  = mk(1,0,0,0,32'h0,        0,0,32'h0000_0000,32'h0);
    vecs[1]  = mk(1,0,0,0,32'h0,        0,1,32'h0000_0000,32'h0);
    vecs[2]  = mk(1,0,0,0,32'h0,        1,1,32'h0000_0004,32'h0000_0000);
    vecs[3]  = mk(1,0,0,0,32'h0,        1,1,32'h0000_0008,32'h0000_0004);
    vecs[4]  = mk(1,1,0,0,32'h0,        1,1,32'h0000_000C,32'h0000_0008);
    vecs[5]  = mk(1,1,0,0,32'h0,        1,0,32'h0000_0010,32'h0000_0008);
    vecs[6]  = mk(1,1,0,0,32'h0,        1,0,32'h0000_0010,32'h0000_0008);
    vecs[7]  = mk(1,1,0,0,32'h0,        1,0,32'h0000_0010,32'h0000_0008);
    vecs[8]  = mk(1,0,0,0,32'h0,        1,0,32'h0000_0010,32'h0000_0008);
    vecs[9]  = mk(1,0,0,0,32'h0,        1,1,32'h0000_0010,32'h0000_000C);
    vecs[10] = mk(1,0,0,0,32'h0,        1,1,32'h0000_0014,32'h0000_0010);
    vecs[11] = mk(0,0,0,0,32'h0,        1,1,32'h0000_0018,32'h0000_0014);
    vecs[12] = mk(0,0,0,0,32'h0,        0,1,32'h0000_0018,32'h0);
    vecs[13] = mk(1,0,0,0,32'h0,        0,1,32'h0000_0018,32'h0);
    vecs[14] = mk(1,0,1,0,32'h0,        1,1,32'h0000_001C,32'h0000_0018);
    vecs[15] = mk(1,0,0,0,32'h0,        1,0,32'h0000_0020,32'h0000_001C);
    vecs[16] = mk(1,0,0,0,32'h0,        0,0,32'h0000_0020,32'h0);
    vecs[17] = mk(1,0,1,1,32'h0000_0043,0,0,32'h0000_0020,32'h0);
    vecs[18] = mk(1,0,0,0,32'h0,        0,1,32'h0000_0040,32'h0);
    vecs[19] = mk(1,0,0,0,32'h0,        1,1,32'h0000_0044,32'h0000_0040);
    vecs[20] = mk(1,1,0,0,32'h0,        1,1,32'h0000_0048,32'h0000_0044);
    vecs[21] = mk(1,1,0,1,32'h0000_1003,1,0,32'h0000_004C,32'h0000_0044);
    vecs[22] = mk(1,0,0,0,32'h0,        0,1,32'h0000_1000,32'h0);
    vecs[23] = mk(1,0,0,0,32'h0,        1,1,32'h0000_1004,32'h0000_1000);
    vecs[24] = mk(1,0,0,1,32'hFFFF_FFF8,1,0,32'h0000_1008,32'h0000_1004);
    vecs[25] = mk(1,0,0,0,32'h0,        0,1,32'hFFFF_FFF8,32'h0);
    vecs[26] = mk(1,0,0,0,32'h0,        1,1,32'hFFFF_FFFC,32'hFFFF_FFF8);
    vecs[27] = mk(1,0,0,0,32'h0,        1,1,32'h0000_0000,32'hFFFF_FFFC);
    vecs[28] = mk(1,0,0,0,32'h0,        1,1,32'h0000_0004,32'h0000_0000);

    reset = 1'b1;
    set_in(0, 0, 0, 0, 32'h0);
    repeat (3) tick();

    chk("reset_rd_en", {31'b0, i_read_en}, 32'h0);
    chk("reset_id",    {31'b0, ID},        32'h0);
    chk("reset_addr",  i_address,          32'h0);
    chk("reset_instr", instr,              32'h0);
    chk("reset_pc_out", pc_out,            32'h0);

    reset = 1'b0;
    for (int i = 0; i < 29; i++) begin
      set_in(vecs[i].rdy, vecs[i].stl, vecs[i].hlt, vecs[i].rdr, vecs[i].tgt);
      #1;
      chk($sformatf("v%0d_id", i),    {31'b0, ID},        {31'b0, vecs[i].e_id});
      chk($sformatf("v%0d_rd_en", i), {31'b0, i_read_en}, {31'b0, vecs[i].e_rd});
      chk($sformatf("v%0d_addr", i),  i_address,          vecs[i].e_addr);
      if (vecs[i].e_id) begin
        chk($sformatf("v%0d_pc_out", i), pc_out, vecs[i].e_pc);
        chk($sformatf("v%0d_instr", i),  instr,  ~vecs[i].e_pc);
      end
      tick();
    end

    // Asynchronous reset in the middle of a cycle while streaming.
    set_in(1, 0, 0, 0, 32'h0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_id",    {31'b0, ID},        32'h0);
    chk("async_rst_rd_en", {31'b0, i_read_en}, 32'h0);
    chk("async_rst_addr",  i_address,          32'h0);
    tick();
    reset = 1'b0;

    // Redirect while in BOOT must be ignored.
    set_in(1, 0, 0, 1, 32'h0000_0080);
    #1;
    chk("boot_rd_en", {31'b0, i_read_en}, 32'h0);
    tick();
    set_in(1, 0, 0, 0, 32'h0);
    #1;
    chk("boot_redir_ignored_addr", i_address, 32'h0);
    chk("boot_first_rd_en", {31'b0, i_read_en}, 32'h1);

    // Random ready (~30%) and stall: the decoder must see a strict +4 sequence.
    exp_pc = 32'h0;
    pops   = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      set_in(($urandom_range(99) < 30), ($urandom_range(99) < 40), 0, 0, 32'h0);
      #1;
      if (ID && !stall) begin
        chk("rand_pc_order", pc_out, exp_pc);
        chk("rand_instr", instr, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    chk("rand_progress", {31'b0, (pops > 20)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
